// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Scan-code prefixes and modifier keys (set 2)
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Codes reported for the extended arrow keys
    localparam logic [7:0] ASC_UP    = 8'h80;
    localparam logic [7:0] ASC_DOWN  = 8'h81;
    localparam logic [7:0] ASC_LEFT  = 8'h82;
    localparam logic [7:0] ASC_RIGHT = 8'h83;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational scan-code to ASCII ROM; 00 means the key is unmapped.
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       upper_alpha,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] lower;

    // Letters resolve to lowercase first, then fold to uppercase if requested
    always_comb begin
        lower = 8'h00;
        ascii = 8'h00;
        if (ext) begin
            case (code)
                8'h75:   ascii = ASC_UP;
                8'h72:   ascii = ASC_DOWN;
                8'h6B:   ascii = ASC_LEFT;
                8'h74:   ascii = ASC_RIGHT;
                default: ascii = 8'h00;
            endcase
        end else begin
            case (code)
                8'h1C: lower = 8'h61;  // a
                8'h32: lower = 8'h62;
                8'h21: lower = 8'h63;
                8'h23: lower = 8'h64;
                8'h24: lower = 8'h65;
                8'h2B: lower = 8'h66;
                8'h34: lower = 8'h67;
                8'h33: lower = 8'h68;
                8'h43: lower = 8'h69;
                8'h3B: lower = 8'h6A;
                8'h42: lower = 8'h6B;
                8'h4B: lower = 8'h6C;
                8'h3A: lower = 8'h6D;
                8'h31: lower = 8'h6E;
                8'h44: lower = 8'h6F;
                8'h4D: lower = 8'h70;
                8'h15: lower = 8'h71;
                8'h2D: lower = 8'h72;
                8'h1B: lower = 8'h73;
                8'h2C: lower = 8'h74;
                8'h3C: lower = 8'h75;
                8'h2A: lower = 8'h76;
                8'h1D: lower = 8'h77;
                8'h22: lower = 8'h78;
                8'h35: lower = 8'h79;
                8'h1A: lower = 8'h7A;  // z
                default: lower = 8'h00;
            endcase
            if (lower != 8'h00) begin
                ascii = upper_alpha ? (lower - 8'h20) : lower;
            end else begin
                // Digit row follows shift only; caps lock has no effect here
                case (code)
                    8'h16:   ascii = shift ? 8'h21 : 8'h31;
                    8'h1E:   ascii = shift ? 8'h40 : 8'h32;
                    8'h26:   ascii = shift ? 8'h23 : 8'h33;
                    8'h25:   ascii = shift ? 8'h24 : 8'h34;
                    8'h2E:   ascii = shift ? 8'h25 : 8'h35;
                    8'h36:   ascii = shift ? 8'h5E : 8'h36;
                    8'h3D:   ascii = shift ? 8'h26 : 8'h37;
                    8'h3E:   ascii = shift ? 8'h2A : 8'h38;
                    8'h46:   ascii = shift ? 8'h28 : 8'h39;
                    8'h45:   ascii = shift ? 8'h29 : 8'h30;
                    8'h29:   ascii = 8'h20;
                    8'h5A:   ascii = 8'h0A;
                    8'h66:   ascii = 8'h08;
                    8'h76:   ascii = 8'h1B;
                    8'h0D:   ascii = 8'h09;
                    default: ascii = 8'h00;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_ascii.sv
// PS/2 frame receiver and key decoder producing ASCII key-press events.
module ps2_ascii
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 25000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       kdone,
    output logic [7:0] ascii
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic [1:0]  clk_sync;
    logic [1:0]  dat_sync;
    logic        clk_prev;
    logic        fall;
    logic        dat;

    rx_state_t   state, state_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic        par, par_next;
    logic [15:0] idle_cnt, idle_next;
    logic        code_valid, code_valid_next;
    logic [7:0]  code, code_next;

    logic        ext, brk, shift_l, shift_r, caps;
    logic [7:0]  map_ascii;

    // Two-stage synchronisers plus previous-clock register for edge detect
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall = clk_prev & ~clk_sync[1];
    assign dat  = dat_sync[1];

    // Receiver state and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            par        <= 1'b0;
            idle_cnt   <= 16'd0;
            code_valid <= 1'b0;
            code       <= 8'h00;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_next;
            par        <= par_next;
            idle_cnt   <= idle_next;
            code_valid <= code_valid_next;
            code       <= code_next;
        end
    end

    // Receiver next state: frame sequencing, validation and idle timeout
    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        shift_next      = shift_reg;
        par_next        = par;
        code_valid_next = 1'b0;
        code_next       = code;
        idle_next       = (state == IDLE || fall) ? 16'd0 : idle_cnt + 16'd1;

        case (state)
            IDLE: begin
                if (fall && !dat) begin
                    state_next   = DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_next   = {dat, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_next   = dat;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                    if ((^{shift_reg, par}) && dat) begin
                        code_valid_next = 1'b1;
                        code_next       = shift_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A fall in the same cycle keeps the frame alive
        if (state != IDLE && !fall && idle_cnt == TIMEOUT_CNT) begin
            state_next = IDLE;
            idle_next  = 16'd0;
        end
    end

    ps2_keymap u_keymap (
        .code        (code),
        .ext         (ext),
        .upper_alpha ((shift_l | shift_r) ^ caps),
        .shift       (shift_l | shift_r),
        .ascii       (map_ascii)
    );

    // Decoder: prefix/modifier tracking and key-press strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            kdone   <= 1'b0;
            ascii   <= 8'h00;
            ext     <= 1'b0;
            brk     <= 1'b0;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            caps    <= 1'b0;
        end else begin
            kdone <= 1'b0;
            if (code_valid) begin
                case (code)
                    SC_EXT: ext <= 1'b1;
                    SC_BRK: brk <= 1'b1;
                    default: begin
                        ext <= 1'b0;
                        brk <= 1'b0;
                        if (code == SC_LSHIFT) begin
                            shift_l <= ~brk;
                        end else if (code == SC_RSHIFT) begin
                            shift_r <= ~brk;
                        end else if (code == SC_CAPS) begin
                            if (!brk) caps <= ~caps;
                        end else if (!brk && map_ascii != 8'h00) begin
                            ascii <= map_ascii;
                            kdone <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
